// File: rtl/life_grid_if.sv
// Command/status bundle for the Game of Life engine.
// With STILL_LIFE_DETECT_EN defined the bundle also carries stable_o.
interface life_grid_if #(
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 16,
  parameter int unsigned GEN_W    = 16,
  parameter int unsigned PERIOD_W = 27
);
  localparam int unsigned XW = $clog2(COLS);
  localparam int unsigned YW = $clog2(ROWS);

  logic                   step_i;
  logic                   run_i;
  logic [PERIOD_W-1:0]    period_i;
  logic                   wrap_i;
  logic                   load_i;
  logic [ROWS*COLS-1:0]   board_i;
  logic                   clear_i;
  logic                   edit_i;
  logic [XW-1:0]          edit_x_i;
  logic [YW-1:0]          edit_y_i;
  logic [ROWS*COLS-1:0]   board_o;
  logic [GEN_W-1:0]       generation_o;
  logic                   busy_o;
  logic                   done_o;

`ifdef STILL_LIFE_DETECT_EN
  logic                   stable_o;

  modport master (
    output step_i, run_i, period_i, wrap_i, load_i, board_i, clear_i, edit_i, edit_x_i, edit_y_i,
    input  board_o, generation_o, busy_o, done_o, stable_o
  );
  modport slave (
    input  step_i, run_i, period_i, wrap_i, load_i, board_i, clear_i, edit_i, edit_x_i, edit_y_i,
    output board_o, generation_o, busy_o, done_o, stable_o
  );
`else
  modport master (
    output step_i, run_i, period_i, wrap_i, load_i, board_i, clear_i, edit_i, edit_x_i, edit_y_i,
    input  board_o, generation_o, busy_o, done_o
  );
  modport slave (
    input  step_i, run_i, period_i, wrap_i, load_i, board_i, clear_i, edit_i, edit_x_i, edit_y_i,
    output board_o, generation_o, busy_o, done_o
  );
`endif
endinterface

// File: rtl/life_grid_engine.sv
// Game of Life engine: one board row per cycle from a snapshot, dead-edge or toroidal.
// Optional still-life detection (stable_o, stops run mode) under STILL_LIFE_DETECT_EN.
module life_grid_engine #(
  parameter int unsigned COLS     = 16,
  parameter int unsigned ROWS     = 16,
  parameter int unsigned GEN_W    = 16,
  parameter int unsigned PERIOD_W = 27
) (
  input logic        clk,
  input logic        reset,
  life_grid_if.slave bus
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int          ColsI = int'(COLS);
  localparam int          RowsI = int'(ROWS);

  typedef enum logic [1:0] {StIdle, StCompute, StCommit} state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        board_q, board_d, snap_q, snap_d, next_q, next_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                wrap_q, wrap_d, auto_q, auto_d, done_q, done_d;
  logic [COLS-1:0]     row_val;
  logic [IdxW-1:0]     edit_idx;
  logic                edit_ok, auto_ok;

`ifdef STILL_LIFE_DETECT_EN
  logic stable_q, stable_d;
  assign bus.stable_o = stable_q;
`else
  logic stable_q;
  assign stable_q = 1'b0;
`endif

  function automatic logic [COLS-1:0] eval_row(input logic [N-1:0] b, input int r,
                                               input logic wrap);
    logic [COLS-1:0] res;
    int              nx, ny;
    int unsigned     cnt;
    logic            self_live;
    res = '0;
    for (int x = 0; x < ColsI; x++) begin
      cnt = 0;
      for (int dy = -1; dy <= 1; dy++) begin
        for (int dx = -1; dx <= 1; dx++) begin
          if (dx != 0 || dy != 0) begin
            nx = x + dx;
            ny = r + dy;
            if (wrap) begin
              nx = (nx + ColsI) % ColsI;
              ny = (ny + RowsI) % RowsI;
            end
            if (nx >= 0 && nx < ColsI && ny >= 0 && ny < RowsI && b[IdxW'(ny * ColsI + nx)]) begin
              cnt++;
            end
          end
        end
      end
      self_live = b[IdxW'(r * ColsI + x)];
      res[ColW'(x)] = (cnt == 3) || (self_live && cnt == 2);
    end
    return res;
  endfunction

  assign row_val  = eval_row(snap_q, int'(row_q), wrap_q);
  assign edit_idx = IdxW'(int'(bus.edit_y_i) * ColsI + int'(bus.edit_x_i));
  assign edit_ok  = (int'(bus.edit_x_i) < ColsI) && (int'(bus.edit_y_i) < RowsI);
  assign auto_ok  = bus.run_i && !stable_q;

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    snap_d  = snap_q;
    next_d  = next_q;
    gen_d   = gen_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    wrap_d  = wrap_q;
    auto_d  = 1'b0;
    done_d  = 1'b0;
`ifdef STILL_LIFE_DETECT_EN
    stable_d = stable_q;
`endif
    unique case (state_q)
      StIdle: begin
        // The auto-step is issued one cycle after the count matches, so the
        // idle gap between a commit and the next auto-step is period_i+1 cycles.
        if (!auto_ok) begin
          cnt_d = '0;
        end else if (!auto_q) begin
          if (cnt_q == bus.period_i) begin
            cnt_d  = '0;
            auto_d = 1'b1;
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        if (bus.load_i) begin
          board_d = bus.board_i;
          gen_d   = '0;
          cnt_d   = '0;
          auto_d  = 1'b0;
`ifdef STILL_LIFE_DETECT_EN
          stable_d = 1'b0;
`endif
        end else if (bus.edit_i) begin
          if (edit_ok) board_d[edit_idx] = ~board_q[edit_idx];
          cnt_d  = '0;
          auto_d = 1'b0;
`ifdef STILL_LIFE_DETECT_EN
          stable_d = 1'b0;
`endif
        end else if (bus.step_i || (auto_q && auto_ok)) begin
          snap_d  = board_q;
          wrap_d  = bus.wrap_i;
          row_d   = '0;
          state_d = StCompute;
        end
      end
      StCompute: begin
        for (int r = 0; r < RowsI; r++) begin
          if (row_q == RowW'(r)) next_d[r*COLS +: COLS] = row_val;
        end
        row_d = row_q + RowW'(1);
        if (row_q == RowW'(ROWS - 1)) state_d = StCommit;
      end
      StCommit: begin
        board_d = next_q;
        gen_d   = gen_q + GEN_W'(1);
        done_d  = 1'b1;
        state_d = StIdle;
`ifdef STILL_LIFE_DETECT_EN
        stable_d = (next_q == snap_q);
`endif
      end
      default: state_d = StIdle;
    endcase
    // Clear overrides everything, including an in-flight generation.
    if (bus.clear_i) begin
      board_d = '0;
      gen_d   = '0;
      cnt_d   = '0;
      auto_d  = 1'b0;
      done_d  = 1'b0;
      state_d = StIdle;
`ifdef STILL_LIFE_DETECT_EN
      stable_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      board_q <= '0;
      snap_q  <= '0;
      next_q  <= '0;
      gen_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef STILL_LIFE_DETECT_EN
      stable_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      snap_q  <= snap_d;
      next_q  <= next_d;
      gen_q   <= gen_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
`ifdef STILL_LIFE_DETECT_EN
      stable_q <= stable_d;
`endif
    end
  end

  assign bus.board_o      = board_q;
  assign bus.generation_o = gen_q;
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.done_o       = done_q;
endmodule
